word_merge_buffer: RTL and testbench

- Single-line write-combining buffer on the CPU store path, between the L1 data port and the physical memory / L2 line port.
- Takes 16-bit word stores with byte enables and inserts them into a 128-bit lc3b_8word line buffer, tracking one written-byte mask bit per byte.
- Drains the buffered line as one masked line write on a tag change, when the line is full, or on an explicit flush.
- Also provides a combinational snoop read port, so that loads can see buffered store data.

---
 rtl/lc3b_types.sv | 27 ++
 rtl/word_merge_buffer_word_insert.sv | 34 +++
 rtl/word_merge_buffer.sv | 136 +++++++++++++
 tb/tb_word_merge_buffer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types.
// Holds the word/line types used across the memory hierarchy, the
// write-combining buffer's line mask/tag types and state encoding, and the
// word-extraction helper used by read paths (L1 read hit, store-buffer snoop).
package lc3b_types;

   localparam int unsigned LINE_BYTES  = 16;
   localparam int unsigned OFFSET_BITS = 4;

   typedef logic [15:0]             lc3b_word;
   typedef logic [127:0]            lc3b_8word;
   typedef logic [LINE_BYTES-1:0]   lc3b_line_mask;
   typedef logic [15-OFFSET_BITS:0] lc3b_line_tag;

   typedef enum logic [1:0] {
      WMB_EMPTY,
      WMB_FILLING,
      WMB_DRAIN
   } wmb_state_t;

   // Word w of a line occupies bits [16w+15:16w].
   function automatic lc3b_word word_extract(input lc3b_8word line,
                                             input logic [2:0] word_idx);
      return line[{word_idx, 4'b0000} +: 16];
   endfunction

endpackage

// File: rtl/word_merge_buffer_word_insert.sv
// word_insert: combinational byte-enabled word write into an 8-word line.
// Write-direction counterpart of word_extract; shared with the L1 write-hit path.
// Ports:
//   line, mask   current line data and written-byte mask
//   word_idx     word index within the line (address bits [3:1])
//   byte_enable  bit 0 -> low byte, bit 1 -> high byte of the word
//   data         store data
//   new_line, new_mask  line and mask with the enabled bytes written
module word_insert
   import lc3b_types::*;
(
   input  lc3b_8word     line,
   input  lc3b_line_mask mask,
   input  logic [2:0]    word_idx,
   input  logic [1:0]    byte_enable,
   input  lc3b_word      data,
   output lc3b_8word     new_line,
   output lc3b_line_mask new_mask
);

   always_comb begin
      new_line = line;
      new_mask = mask;
      if (byte_enable[0]) begin
         new_line[{word_idx, 4'b0000} +: 8] = data[7:0];
         new_mask[{word_idx, 1'b0}]         = 1'b1;
      end
      if (byte_enable[1]) begin
         new_line[{word_idx, 4'b1000} +: 8] = data[15:8];
         new_mask[{word_idx, 1'b1}]         = 1'b1;
      end
   end

endmodule

// File: rtl/word_merge_buffer.sv
// word_merge_buffer: single-line write-combining buffer on the CPU store path.
// 16-bit stores are merged into one 128-bit line with a per-byte written mask;
// the line drains as one masked line write on a tag change, when full, or on
// flush. A combinational snoop port exposes buffered bytes to loads.
// Ports:
//   clk, reset_n                          clock, async active-low reset
//   cpu_write/cpu_address/cpu_wdata/cpu_byte_enable -> cpu_resp   store port
//   flush -> flush_done                   drain request / completion pulse
//   snoop_address -> snoop_data, snoop_mask   load-side lookup
//   mem_write/mem_address/mem_wdata/mem_byte_mask <- mem_resp   line write port
//   buffer_valid                          buffer holds written bytes
module word_merge_buffer
   import lc3b_types::*;
(
   input  logic          clk,
   input  logic          reset_n,
   input  logic          cpu_write,
   input  lc3b_word      cpu_address,
   input  lc3b_word      cpu_wdata,
   input  logic [1:0]    cpu_byte_enable,
   output logic          cpu_resp,
   input  logic          flush,
   output logic          flush_done,
   input  lc3b_word      snoop_address,
   output lc3b_word      snoop_data,
   output logic [1:0]    snoop_mask,
   output logic          mem_write,
   output lc3b_word      mem_address,
   output lc3b_8word     mem_wdata,
   output lc3b_line_mask mem_byte_mask,
   input  logic          mem_resp,
   output logic          buffer_valid
);

   wmb_state_t    state, next_state;
   lc3b_line_tag  tag;
   lc3b_8word     line;
   lc3b_line_mask mask;
   logic          flush_q;
   logic          drain_by_flush;

   lc3b_8word     ins_line;
   lc3b_line_mask ins_mask;
   logic          tag_match;
   logic          accept;
   logic          merge;
   logic          unused_addr_bits;

   assign unused_addr_bits = ^{cpu_address[0], snoop_address[0]};

   assign tag_match = (cpu_address[15:OFFSET_BITS] == tag);
   // cpu_resp high means the held request was just taken; don't take it twice.
   assign accept = cpu_write && !cpu_resp && !flush &&
                   ((state == WMB_EMPTY) || ((state == WMB_FILLING) && tag_match));
   assign merge  = accept && (cpu_byte_enable != 2'b00);

   word_insert u_word_insert (
      .line        (line),
      .mask        (mask),
      .word_idx    (cpu_address[3:1]),
      .byte_enable (cpu_byte_enable),
      .data        (cpu_wdata),
      .new_line    (ins_line),
      .new_mask    (ins_mask)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= WMB_EMPTY;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         WMB_EMPTY: begin
            if (merge) next_state = WMB_FILLING;
         end
         WMB_FILLING: begin
            if (flush)                        next_state = WMB_DRAIN;
            else if (cpu_write && !tag_match) next_state = WMB_DRAIN;
            else if (merge && (ins_mask == '1)) next_state = WMB_DRAIN;
         end
         WMB_DRAIN: begin
            if (mem_resp) next_state = WMB_EMPTY;
         end
         default: next_state = WMB_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tag            <= '0;
         line           <= '0;
         mask           <= '0;
         cpu_resp       <= 1'b0;
         flush_done     <= 1'b0;
         flush_q        <= 1'b0;
         drain_by_flush <= 1'b0;
      end else begin
         cpu_resp   <= accept;
         flush_q    <= flush;
         flush_done <= 1'b0;
         if (merge) begin
            line <= ins_line;
            mask <= ins_mask;
            if (state == WMB_EMPTY) tag <= cpu_address[15:OFFSET_BITS];
         end
         case (state)
            // Edge-detect so a flush held across a drain completes only once.
            WMB_EMPTY:   if (flush && !flush_q) flush_done <= 1'b1;
            // Tracks the cause of the drain; frozen once DRAIN is entered.
            WMB_FILLING: drain_by_flush <= flush;
            // Clearing the line keeps unwritten lanes at 0 for the next fill.
            WMB_DRAIN: begin
               if (mem_resp) begin
                  line       <= '0;
                  mask       <= '0;
                  flush_done <= drain_by_flush;
               end
            end
            default: ;
         endcase
      end
   end

   assign buffer_valid  = (state != WMB_EMPTY);
   assign mem_write     = (state == WMB_DRAIN);
   assign mem_address   = {tag, {OFFSET_BITS{1'b0}}};
   assign mem_wdata     = line;
   assign mem_byte_mask = mask;

   assign snoop_data = word_extract(line, snoop_address[3:1]);
   assign snoop_mask = (buffer_valid && (snoop_address[15:OFFSET_BITS] == tag))
                       ? mask[{snoop_address[3:1], 1'b0} +: 2] : 2'b00;

endmodule

// File: tb/tb_word_merge_buffer.sv
module tb_word_merge_buffer;
   import lc3b_types::*;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          cpu_write = 1'b0;
   logic [15:0]   cpu_address = '0;
   logic [15:0]   cpu_wdata = '0;
   logic [1:0]    cpu_byte_enable = '0;
   logic          cpu_resp;
   logic          flush = 1'b0;
   logic          flush_done;
   logic [15:0]   snoop_address = '0;
   logic [15:0]   snoop_data;
   logic [1:0]    snoop_mask;
   logic          mem_write;
   logic [15:0]   mem_address;
   logic [127:0]  mem_wdata;
   logic [15:0]   mem_byte_mask;
   logic          mem_resp = 1'b0;
   logic          buffer_valid;

   typedef struct {
      logic [15:0]  addr;
      logic [127:0] data;
      logic [15:0]  mask;
   } line_wr_t;

   line_wr_t sb[$];
   int unsigned checks = 0;
   int unsigned passed = 0;

   word_merge_buffer dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .cpu_write       (cpu_write),
      .cpu_address     (cpu_address),
      .cpu_wdata       (cpu_wdata),
      .cpu_byte_enable (cpu_byte_enable),
      .cpu_resp        (cpu_resp),
      .flush           (flush),
      .flush_done      (flush_done),
      .snoop_address   (snoop_address),
      .snoop_data      (snoop_data),
      .snoop_mask      (snoop_mask),
      .mem_write       (mem_write),
      .mem_address     (mem_address),
      .mem_wdata       (mem_wdata),
      .mem_byte_mask   (mem_byte_mask),
      .mem_resp        (mem_resp),
      .buffer_valid    (buffer_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", passed, checks);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_line(input logic [15:0] a, input logic [127:0] d, input logic [15:0] m);
      line_wr_t e;
      e.addr = a; e.data = d; e.mask = m;
      sb.push_back(e);
   endtask

   task automatic do_store(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be,
                           output int waited);
      cpu_address = a; cpu_wdata = d; cpu_byte_enable = be; cpu_write = 1'b1;
      waited = 0;
      do begin
         tick();
         waited++;
      end while (!cpu_resp && waited < 50);
      cpu_write = 1'b0;
      checks++;
      if (cpu_resp !== 1'b1) $display("FAIL store_resp @%h: cpu_resp=%b required 1 (timeout)", a, cpu_resp);
      else passed++;
   endtask

   task automatic expect_line_write(input string name, input int max_cycles);
      line_wr_t e;
      int n = 0;
      while (mem_write !== 1'b1 && n < max_cycles) begin
         tick();
         n++;
      end
      checks++;
      if (mem_write !== 1'b1) begin
         $display("FAIL %s_mem_write: mem_write=%b required 1 within %0d cycles", name, mem_write, max_cycles);
      end else if (sb.size() == 0) begin
         $display("FAIL %s_scoreboard: line write seen with no expected entry", name);
      end else begin
         passed++;
         e = sb.pop_front();
         checks++;
         if (mem_address !== e.addr) $display("FAIL %s_addr: got %h required %h", name, mem_address, e.addr);
         else passed++;
         checks++;
         if (mem_wdata !== e.data) $display("FAIL %s_wdata: got %h required %h", name, mem_wdata, e.data);
         else passed++;
         checks++;
         if (mem_byte_mask !== e.mask) $display("FAIL %s_mask: got %h required %h", name, mem_byte_mask, e.mask);
         else passed++;
      end
   endtask

   task automatic mem_ack();
      mem_resp = 1'b1;
      tick();
      mem_resp = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) tick();
      checks++;
      if ({cpu_resp, flush_done, mem_write, buffer_valid} !== 4'b0000)
         $display("FAIL reset_ctrl: resp/fdone/mwrite/valid=%b required 0000",
                  {cpu_resp, flush_done, mem_write, buffer_valid});
      else passed++;
      checks++;
      if ({mem_address, mem_wdata, mem_byte_mask} !== '0)
         $display("FAIL reset_mem: addr=%h data=%h mask=%h required all 0", mem_address, mem_wdata, mem_byte_mask);
      else passed++;
      checks++;
      if (snoop_mask !== 2'b00) $display("FAIL reset_snoop: snoop_mask=%b required 00", snoop_mask);
      else passed++;
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_single_store();
      int w;
      logic [127:0] d;
      do_store(16'h1236, 16'hBEEF, 2'b11, w);
      checks++;
      if (w != 1) $display("FAIL single_latency: cpu_resp after %0d cycles required 1", w);
      else passed++;
      checks++;
      if (buffer_valid !== 1'b1) $display("FAIL single_valid: buffer_valid=%b required 1", buffer_valid);
      else passed++;
      snoop_address = 16'h1236;
      #1;
      checks++;
      if ({snoop_data, snoop_mask} !== {16'hBEEF, 2'b11})
         $display("FAIL single_snoop: data=%h mask=%b required beef 11", snoop_data, snoop_mask);
      else passed++;
      d = '0;
      d[63:48] = 16'hBEEF;
      push_line(16'h1230, d, 16'h00C0);
      flush = 1'b1;
      expect_line_write("single", 5);
      mem_ack();
      checks++;
      if ({flush_done, mem_write, buffer_valid} !== 3'b100)
         $display("FAIL single_flush_done: fdone/mwrite/valid=%b required 100", {flush_done, mem_write, buffer_valid});
      else passed++;
      tick();
      checks++;
      if (flush_done !== 1'b0) $display("FAIL single_flush_once: flush_done=%b required 0", flush_done);
      else passed++;
      flush = 1'b0;
      tick();
   endtask

   task automatic test_byte_merge();
      int w;
      logic [127:0] d;
      do_store(16'h2000, 16'hAA11, 2'b01, w);
      do_store(16'h2000, 16'h22BB, 2'b10, w);
      do_store(16'h2004, 16'hFFFF, 2'b00, w);
      snoop_address = 16'h2000;
      #1;
      checks++;
      if ({snoop_data, snoop_mask} !== {16'h2211, 2'b11})
         $display("FAIL merge_snoop: data=%h mask=%b required 2211 11", snoop_data, snoop_mask);
      else passed++;
      snoop_address = 16'h2004;
      #1;
      checks++;
      if (snoop_mask !== 2'b00) $display("FAIL merge_be0_snoop: mask=%b required 00", snoop_mask);
      else passed++;
      snoop_address = 16'h3000;
      #1;
      checks++;
      if (snoop_mask !== 2'b00) $display("FAIL merge_tag_miss: mask=%b required 00", snoop_mask);
      else passed++;
      checks++;
      if (mem_write !== 1'b0) $display("FAIL merge_no_write: mem_write=%b required 0", mem_write);
      else passed++;
      d = '0;
      d[15:0] = 16'h2211;
      push_line(16'h2000, d, 16'h0003);
      flush = 1'b1;
      expect_line_write("merge", 5);
      mem_ack();
      flush = 1'b0;
      tick();
   endtask

   task automatic test_fill_full();
      int w;
      logic [127:0] d;
      logic [15:0] v;
      d = '0;
      for (int i = 0; i < 8; i++) d[16*i +: 16] = 16'h3100 + 16'(i * 16'h0111);
      push_line(16'h3000, d, 16'hFFFF);
      for (int i = 0; i < 8; i++) begin
         v = 16'h3100 + 16'(i * 16'h0111);
         do_store(16'h3000 + 16'(2 * i), v, 2'b11, w);
         checks++;
         if (mem_write !== (i == 7)) $display("FAIL fill_drain_%0d: mem_write=%b required %b", i, mem_write, (i == 7));
         else passed++;
      end
      expect_line_write("fill", 0);
      mem_ack();
      checks++;
      if ({flush_done, buffer_valid} !== 2'b00)
         $display("FAIL fill_after: fdone/valid=%b required 00", {flush_done, buffer_valid});
      else passed++;
      tick();
   endtask

   task automatic test_tag_conflict();
      int w;
      int n;
      logic [127:0] d;
      logic [127:0] d5;
      do_store(16'h4000, 16'h1234, 2'b11, w);
      d = '0;
      d[15:0] = 16'h1234;
      push_line(16'h4000, d, 16'h0003);
      cpu_address = 16'h5002; cpu_wdata = 16'h5678; cpu_byte_enable = 2'b11; cpu_write = 1'b1;
      expect_line_write("conflict", 5);
      snoop_address = 16'h4000;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if ({mem_write, mem_address, mem_byte_mask, cpu_resp, buffer_valid, snoop_mask, snoop_data} !==
             {1'b1, 16'h4000, 16'h0003, 1'b0, 1'b1, 2'b11, 16'h1234} || mem_wdata !== d)
            $display("FAIL stall_%0d: mw=%b addr=%h mask=%h resp=%b valid=%b smask=%b sdata=%h data=%h",
                     i, mem_write, mem_address, mem_byte_mask, cpu_resp, buffer_valid, snoop_mask, snoop_data, mem_wdata);
         else passed++;
      end
      mem_ack();
      checks++;
      if (cpu_resp !== 1'b0) $display("FAIL conflict_early_resp: cpu_resp=%b required 0", cpu_resp);
      else passed++;
      n = 0;
      while (!cpu_resp && n < 10) begin
         tick();
         n++;
      end
      cpu_write = 1'b0;
      checks++;
      if (n != 1) $display("FAIL conflict_accept: cpu_resp after %0d cycles required 1", n);
      else passed++;
      snoop_address = 16'h5002;
      #1;
      checks++;
      if ({snoop_data, snoop_mask, mem_byte_mask} !== {16'h5678, 2'b11, 16'h000C})
         $display("FAIL conflict_new: sdata=%h smask=%b mask=%h required 5678 11 000c", snoop_data, snoop_mask, mem_byte_mask);
      else passed++;
      d5 = '0;
      d5[31:16] = 16'h5678;
      push_line(16'h5000, d5, 16'h000C);
      flush = 1'b1;
      expect_line_write("conflict_new", 5);
      mem_ack();
      flush = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_drain();
      int w;
      int n;
      logic seen_write;
      do_store(16'h6000, 16'hABCD, 2'b11, w);
      flush = 1'b1;
      tick();
      checks++;
      if (mem_write !== 1'b1) $display("FAIL rst_drain_enter: mem_write=%b required 1", mem_write);
      else passed++;
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({mem_write, buffer_valid, mem_byte_mask} !== '0)
         $display("FAIL rst_async: mw=%b valid=%b mask=%h required 0", mem_write, buffer_valid, mem_byte_mask);
      else passed++;
      flush = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      tick();
      flush = 1'b1;
      seen_write = 1'b0;
      n = 0;
      while (!flush_done && n < 10) begin
         tick();
         n++;
         if (mem_write) seen_write = 1'b1;
      end
      checks++;
      if ({flush_done, seen_write} !== 2'b10)
         $display("FAIL rst_flush: flush_done=%b mem_write_seen=%b required 1 0", flush_done, seen_write);
      else passed++;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({flush_done, mem_write} !== 2'b00)
            $display("FAIL rst_flush_held_%0d: fdone/mw=%b required 00", i, {flush_done, mem_write});
         else passed++;
      end
      flush = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_single_store();
      test_byte_merge();
      test_fill_full();
      test_tag_conflict();
      test_reset_mid_drain();
      checks++;
      if (sb.size() != 0) $display("FAIL scoreboard_empty: %0d line writes never seen, required 0", sb.size());
      else passed++;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
